// File: rtl/fd_bridge_pkg.sv
// fd_bridge shared types: FSM state encoding and AXI4-Lite response codes.
package fd_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_DONE = 3'd6
  } Bridge_state;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY = 2'b00;

  function automatic logic resp_is_err(input axi_resp_t r);
    return r != RESP_OKAY;
  endfunction

endpackage

// File: rtl/fd_bridge_if.sv
// AXI4-Lite channel bundle between fd_bridge (master) and the pseudo-DRAM (slave).
interface fd_bridge_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
) ();

  logic                   AR_VALID;
  logic                   AR_READY;
  logic [ADDR_W-1:0]      AR_ADDR;
  logic                   R_VALID;
  logic                   R_READY;
  logic [DATA_W-1:0]      R_DATA;
  fd_bridge_pkg::axi_resp_t R_RESP;
  logic                   AW_VALID;
  logic                   AW_READY;
  logic [ADDR_W-1:0]      AW_ADDR;
  logic                   W_VALID;
  logic                   W_READY;
  logic [DATA_W-1:0]      W_DATA;
  logic                   B_VALID;
  logic                   B_READY;
  fd_bridge_pkg::axi_resp_t B_RESP;

  modport master (
    output AR_VALID, AR_ADDR, R_READY,
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP,
    input  AW_READY, W_READY, B_VALID, B_RESP
  );

  modport slave (
    input  AR_VALID, AR_ADDR, R_READY,
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP,
    output AW_READY, W_READY, B_VALID, B_RESP
  );

endinterface

// File: rtl/fd_bridge.sv
// FD request port to AXI4-Lite DRAM bridge: one transaction per request,
// single-cycle completion pulse, all outputs registered.
module fd_bridge
  import fd_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 17,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              C_in_valid,
  input  logic [7:0]        C_addr,
  input  logic              C_r_wb,
  input  logic [DATA_W-1:0] C_data_w,
  output logic              C_out_valid,
  output logic [DATA_W-1:0] C_data_r,
  output logic              C_resp_err,
  fd_bridge_if.master       axi
);

  Bridge_state state_q, state_d;

  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              req_rwb_q, req_rwb_d;

  logic              ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              r_ready_q, r_ready_d;
  logic              aw_valid_q, aw_valid_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_valid_q, w_valid_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              b_ready_q, b_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] data_r_q, data_r_d;
  logic              resp_err_q, resp_err_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = ar_valid_q && axi.AR_READY;
  assign r_hs  = r_ready_q  && axi.R_VALID;
  assign aw_hs = aw_valid_q && axi.AW_READY;
  assign w_hs  = w_valid_q  && axi.W_READY;
  assign b_hs  = b_ready_q  && axi.B_VALID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (C_in_valid) state_d = C_r_wb ? S_AR : S_AW;
      S_AR:   if (ar_hs) state_d = S_R;
      S_R:    if (r_hs)  state_d = S_DONE;
      S_AW:   if (aw_hs) state_d = S_W;
      S_W:    if (w_hs)  state_d = S_B;
      S_B:    if (b_hs)  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_rwb_d  = req_rwb_q;
    if (state_q == S_IDLE && C_in_valid) begin
      req_addr_d = BASE_ADDR + ADDR_W'({C_addr, 3'b000});
      req_data_d = C_data_w;
      req_rwb_d  = C_r_wb;
    end
  end

  // Address VALIDs rise one cycle after entry, from the latched request.
  always_comb begin
    ar_valid_d  = (state_q == S_AR) && !ar_hs;
    ar_addr_d   = ar_valid_d ? req_addr_q : '0;
    aw_valid_d  = (state_q == S_AW) && !aw_hs;
    aw_addr_d   = aw_valid_d ? req_addr_q : '0;
    r_ready_d   = (state_d == S_R);
    w_valid_d   = (state_d == S_W);
    w_data_d    = w_valid_d ? req_data_q : '0;
    b_ready_d   = (state_d == S_B);
    out_valid_d = (state_d == S_DONE);
    data_r_d    = '0;
    resp_err_d  = 1'b0;
    unique case (1'b1)
      r_hs: begin
        data_r_d   = axi.R_DATA;
        resp_err_d = resp_is_err(axi.R_RESP);
      end
      b_hs: resp_err_d = resp_is_err(axi.B_RESP);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_rwb_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      b_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      data_r_q    <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_rwb_q   <= req_rwb_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      r_ready_q   <= r_ready_d;
      aw_valid_q  <= aw_valid_d;
      aw_addr_q   <= aw_addr_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      b_ready_q   <= b_ready_d;
      out_valid_q <= out_valid_d;
      data_r_q    <= data_r_d;
      resp_err_q  <= resp_err_d;
    end
  end

  logic unused_rwb;
  assign unused_rwb = req_rwb_q;

  assign axi.AR_VALID = ar_valid_q;
  assign axi.AR_ADDR  = ar_addr_q;
  assign axi.R_READY  = r_ready_q;
  assign axi.AW_VALID = aw_valid_q;
  assign axi.AW_ADDR  = aw_addr_q;
  assign axi.W_VALID  = w_valid_q;
  assign axi.W_DATA   = w_data_q;
  assign axi.B_READY  = b_ready_q;
  assign C_out_valid  = out_valid_q;
  assign C_data_r     = data_r_q;
  assign C_resp_err   = resp_err_q;

endmodule

// File: doc/fd_bridge.md
# fd_bridge

Bridge between the FD controller's simple cache-style request port and the AXI4-Lite DRAM slave that stores per-ID `Dram_data` records. The FD controller issues one read or write per request. The bridge performs the matching AXI4-Lite read or write transaction and returns a single-cycle completion. It is the responder on the FD side and the initiator on the DRAM side. It sits between the FD top and the pseudo-DRAM.

## Interface
Parameters:
- BASE_ADDR, 17'h10000, byte address of record ID 0
- ADDR_W, 17, AXI address width
- DATA_W, 64, record width (= width of `Dram_data`)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- C_in_valid  in  1  request strobe, sampled only in IDLE
- C_addr  in  8  record ID (restaurant / delivery-man ID)
- C_r_wb  in  1  1 = read, 0 = write
- C_data_w  in  64  write data (`Dram_data` packed)
- C_out_valid  out  1  one-cycle completion pulse
- C_data_r  out  64  read data, valid with C_out_valid
- C_resp_err  out  1  RESP != OKAY on this transaction, valid with C_out_valid
- AR_VALID / AR_READY  out / in  1  read address handshake
- AR_ADDR  out  17  read address
- R_VALID / R_READY  in / out  1  read data handshake
- R_DATA  in  64  read data
- R_RESP  in  2  read response
- AW_VALID / AW_READY  out / in  1  write address handshake
- AW_ADDR  out  17  write address
- W_VALID / W_READY  out / in  1  write data handshake
- W_DATA  out  64  write data
- B_VALID / B_READY  in / out  1  write response handshake
- B_RESP  in  2  write response

## Operation
Address: BASE_ADDR + {C_addr, 3'b000}, computed in ADDR_W bits. Overflow cannot occur for 8-bit IDs with the default base.

Request capture:
- In IDLE, C_in_valid = 1 latches C_addr, C_r_wb and C_data_w.
- C_in_valid outside IDLE is ignored. The FD controller guarantees one outstanding request.

FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE -> AR (read) or AW (write) on C_in_valid.
- AR: AR_VALID = 1, AR_ADDR = latched address. Go to R when AR_VALID && AR_READY.
- R: R_READY = 1. On R_VALID, capture R_DATA into C_data_r, capture (R_RESP != 0) into the error flag, go to DONE.
- AW: AW_VALID = 1, AW_ADDR = latched address. Go to W on AW_READY.
- W: W_VALID = 1, W_DATA = latched data. Go to B on W_READY.
- B: B_READY = 1. On B_VALID, capture (B_RESP != 0), go to DONE.
- DONE: C_out_valid = 1 for exactly one cycle, then IDLE.

Handshake and data rules:
- Write data is sent only after the AW handshake completes; AW and W are never overlapped.
- VALID, once asserted, is held with stable ADDR/DATA until READY. VALID never depends combinationally on READY.
- All AXI outputs and C_* outputs are registered.
- ADDR/DATA outputs are 0 whenever their VALID is 0.
- C_data_r is 0 except in the DONE cycle of a read; it is 0 on write completion.
- A non-OKAY response still completes normally; only C_resp_err flags it. No retry.
- READY arriving in the same cycle VALID first rises counts as a handshake.

## Timing
- Reset value of every output is 0. FSM resets to IDLE; latched request and error flag reset to 0.
- Reset asserted mid-transaction aborts immediately: all VALID/READY drop asynchronously and no C_out_valid is issued. The FD controller must re-issue the request.
- Request sampled at edge t0. Minimum read latency: AR_VALID at t1, R_READY at t2, C_out_valid at t3.
- Minimum write latency: AW_VALID at t1, W_VALID at t2, B_READY at t3, C_out_valid at t4.
- Each cycle of AXI stall adds one cycle of latency. There is no timeout.
- Earliest acceptance of a new request: the cycle after C_out_valid.

## Structure
- Add enum `Bridge_state` (logic [2:0], the seven states above) to the shared `usertype` package.
- C_data_w / C_data_r carry `Dram_data`. The bridge treats them as opaque 64-bit vectors: no field swap, no byte reorder.
- Single flat module; no sub-module is warranted.

## Test plan
- Read, slave always ready: C_addr = 8'h05, R_DATA = 64'h0123_4567_89AB_CDEF, R_RESP = 0 -> AR_ADDR = 17'h10028, C_out_valid at t3, C_data_r = 64'h0123_4567_89AB_CDEF, C_resp_err = 0.
- Write with stalls: C_addr = 8'hFF, data 64'hDEAD_BEEF_0000_0001; AW_READY delayed 3 cycles, W_READY delayed 2 cycles -> AW_ADDR = 17'h107F8 held stable; W_VALID rises only after the AW handshake; W_DATA matches; C_out_valid once; C_data_r = 0.
- Error response: read with R_RESP = 2'b10 -> C_out_valid = 1, C_resp_err = 1, C_data_r = R_DATA. Next request gives C_resp_err = 0.
- C_in_valid pulsed while in R state with a different C_addr -> ignored; only one completion, carrying the original address's data.
- rst asserted while in W -> W_VALID drops with no clock edge needed; all outputs 0; no C_out_valid. A request after reset completes normally.
